// File: rtl/memory_arbiter_if.sv
// RAM status encoding shared by the arbiter and its environment, plus the
// request/response and RAM-side bus bundle the arbiter sits on.
package memory_arbiter_pkg;
  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BUSY   = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } ramstate_t;
endpackage

interface memory_arbiter_if;
  import memory_arbiter_pkg::*;

  logic        iREN;
  logic [31:0] iaddr;
  logic        dREN;
  logic        dWEN;
  logic [31:0] daddr;
  logic [31:0] dstore;
  logic        ihit;
  logic [31:0] iload;
  logic        dhit;
  logic [31:0] dload;
  logic        ramREN;
  logic        ramWEN;
  logic [31:0] ramaddr;
  logic [31:0] ramstore;
  logic [31:0] ramload;
  ramstate_t   ramstate;
  logic        mem_err;

  // Arbiter side.
  modport slave (
    input  iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
    output ihit, iload, dhit, dload, ramREN, ramWEN, ramaddr, ramstore, mem_err
  );

  // Environment side: datapath requester and RAM model together.
  modport master (
    output iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
    input  ihit, iload, dhit, dload, ramREN, ramWEN, ramaddr, ramstore, mem_err
  );
endinterface

// File: rtl/memory_arbiter.sv
// Single-outstanding-request arbiter between fetch/data request levels and a
// single-ported RAM with variable latency; returns one-cycle hit pulses.
module memory_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter logic [31:0] ERR_WORD       = 32'hBAD1BAD1
) (
  input  logic            CLK,
  input  logic            RST,
  memory_arbiter_if.slave bus
);
  import memory_arbiter_pkg::*;

  localparam logic [7:0] TIMEOUT_LIMIT = 8'(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {IDLE, DACC, IACC, RESP} state_t;

  state_t      state, state_next;
  logic        write_q, write_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] store_q, store_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        ren_q, ren_d;
  logic        wen_q, wen_d;
  logic        ihit_q, ihit_d;
  logic        dhit_q, dhit_d;
  logic [31:0] iload_q, iload_d;
  logic [31:0] dload_q, dload_d;
  logic        err_q, err_d;
  logic        finish;

  // NOTE: every output is a flop, so strobes and hits never follow the request
  // inputs combinationally; this process only computes next values.
  always_comb begin
    // NOTE: each variable gets a default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    state_next = state;
    write_d    = write_q;
    addr_d     = addr_q;
    store_d    = store_q;
    cnt_d      = cnt_q;
    ren_d      = 1'b0;
    wen_d      = 1'b0;
    ihit_d     = 1'b0;
    dhit_d     = 1'b0;
    iload_d    = iload_q;
    dload_d    = dload_q;
    err_d      = err_q;
    finish     = 1'b0;

    case (state)
      IDLE: begin
        if (bus.dREN || bus.dWEN) begin
          // A simultaneous read and write request is treated as a write.
          state_next = DACC;
          write_d    = bus.dWEN;
          addr_d     = bus.daddr;
          store_d    = bus.dstore;
          wen_d      = bus.dWEN;
          ren_d      = ~bus.dWEN;
          cnt_d      = 8'd0;
        end else if (bus.iREN) begin
          state_next = IACC;
          write_d    = 1'b0;
          addr_d     = bus.iaddr;
          ren_d      = 1'b1;
          cnt_d      = 8'd0;
        end
      end

      DACC, IACC: begin
        if (bus.ramstate == ACCESS) begin
          finish = 1'b1;
          if (state == IACC)  iload_d = bus.ramload;
          else if (!write_q)  dload_d = bus.ramload;
        end else if (cnt_q == TIMEOUT_LIMIT) begin
          finish = 1'b1;
          err_d  = 1'b1;
          if (state == IACC)  iload_d = ERR_WORD;
          else if (!write_q)  dload_d = ERR_WORD;
        end else begin
          // FREE, BUSY and ERROR all hold the access; ERROR acts as a retry.
          cnt_d = cnt_q + 8'd1;
          ren_d = ren_q;
          wen_d = wen_q;
        end

        if (finish) begin
          state_next = RESP;
          ihit_d     = (state == IACC);
          dhit_d     = (state == DACC);
        end
      end

      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the values from before this edge, independent of statement order.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state   <= IDLE;
      write_q <= 1'b0;
      addr_q  <= '0;
      store_q <= '0;
      cnt_q   <= '0;
      ren_q   <= 1'b0;
      wen_q   <= 1'b0;
      ihit_q  <= 1'b0;
      dhit_q  <= 1'b0;
      iload_q <= '0;
      dload_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state   <= state_next;
      write_q <= write_d;
      addr_q  <= addr_d;
      store_q <= store_d;
      cnt_q   <= cnt_d;
      ren_q   <= ren_d;
      wen_q   <= wen_d;
      ihit_q  <= ihit_d;
      dhit_q  <= dhit_d;
      iload_q <= iload_d;
      dload_q <= dload_d;
      err_q   <= err_d;
    end
  end

  assign bus.ramREN   = ren_q;
  assign bus.ramWEN   = wen_q;
  assign bus.ramaddr  = addr_q;
  assign bus.ramstore = store_q;
  assign bus.ihit     = ihit_q;
  assign bus.dhit     = dhit_q;
  assign bus.iload    = iload_q;
  assign bus.dload    = dload_q;
  assign bus.mem_err  = err_q;
endmodule

// File: tb/tb_memory_arbiter.sv
// Directed bench for memory_arbiter: stimulus pushes expected hits into a
// scoreboard; a negedge monitor pops and compares every hit pulse.
module tb_memory_arbiter;
  import memory_arbiter_pkg::*;

  typedef struct {
    logic        is_d;
    logic [31:0] load;
    int          cyc;
    string       name;
  } exp_t;

  logic CLK;
  logic RST;
  memory_arbiter_if bus ();

  memory_arbiter #(
    .TIMEOUT_CYCLES(4),
    .ERR_WORD      (32'hBAD1BAD1)
  ) dut (
    .CLK(CLK),
    .RST(RST),
    .bus(bus)
  );

  int        checks = 0;
  int        errors = 0;
  int        cyc    = 0;
  int        pops   = 0;
  int        pushes = 0;
  exp_t      sb[$];

  // RAM model: stalls with stall_state for wait_cycles strobe cycles, then ACCESS.
  ramstate_t   stall_state = BUSY;
  int          wait_cycles = 0;
  int          acc_cnt     = 0;
  logic        saw_ren     = 1'b0;
  logic [31:0] wr_addr     = '0;
  logic [31:0] wr_data     = '0;

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  always @(posedge CLK) cyc <= cyc + 1;

  always @(posedge CLK) begin
    acc_cnt <= (bus.ramREN || bus.ramWEN) ? acc_cnt + 1 : 0;
    if (bus.ramWEN && bus.ramstate == ACCESS) begin
      wr_addr <= bus.ramaddr;
      wr_data <= bus.ramstore;
    end
  end

  assign bus.ramstate = (bus.ramREN || bus.ramWEN)
                      ? ((acc_cnt >= wait_cycles) ? ACCESS : stall_state) : FREE;
  assign bus.ramload  = (bus.ramaddr == 32'h100) ? 32'hDEADBEEF :
                        (bus.ramaddr == 32'h40)  ? 32'h8C010004 :
                        (bus.ramaddr ^ 32'hA5A5_0000);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every hit pulse must match the head of the scoreboard.
  always @(negedge CLK) begin
    if (bus.ramREN) saw_ren = 1'b1;
    if (bus.ihit || bus.dhit) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_hit: ihit=%0b dhit=%0b with empty scoreboard (cycle %0d)",
                 bus.ihit, bus.dhit, cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check({e.name, "_dhit"}, {31'b0, bus.dhit}, {31'b0, e.is_d});
        check({e.name, "_ihit"}, {31'b0, bus.ihit}, {31'b0, ~e.is_d});
        check({e.name, "_load"}, e.is_d ? bus.dload : bus.iload, e.load);
        check({e.name, "_cycle"}, 32'(cyc), 32'(e.cyc));
        pops++;
      end
    end
  end

  task automatic goto(input int c);
    while (cyc < c) begin
      @(posedge CLK);
      #1;
    end
  endtask

  task automatic expect_hit(input logic is_d, input logic [31:0] load, input int c,
                            input string name);
    exp_t e;
    e.is_d = is_d;
    e.load = load;
    e.cyc  = c;
    e.name = name;
    sb.push_back(e);
    pushes++;
  endtask

  task automatic wait_hits(input string name, input int budget);
    int lim;
    lim = cyc + budget;
    while (pops < pushes && cyc < lim) begin
      @(posedge CLK);
      #1;
    end
    if (pops < pushes) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: got %0d hits expected %0d", name, pops, pushes);
    end
  endtask

  task automatic check_reset_outputs(input string name);
    check({name, "_ihit"},     {31'b0, bus.ihit},    32'h0);
    check({name, "_dhit"},     {31'b0, bus.dhit},    32'h0);
    check({name, "_ramREN"},   {31'b0, bus.ramREN},  32'h0);
    check({name, "_ramWEN"},   {31'b0, bus.ramWEN},  32'h0);
    check({name, "_ramaddr"},  bus.ramaddr,          32'h0);
    check({name, "_ramstore"}, bus.ramstore,         32'h0);
    check({name, "_iload"},    bus.iload,            32'h0);
    check({name, "_dload"},    bus.dload,            32'h0);
    check({name, "_mem_err"},  {31'b0, bus.mem_err}, 32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int c0;
    RST        = 1'b1;
    bus.iREN   = 1'b0;
    bus.iaddr  = '0;
    bus.dREN   = 1'b0;
    bus.dWEN   = 1'b0;
    bus.daddr  = '0;
    bus.dstore = '0;

    // Reset state
    goto(2);
    @(negedge CLK);
    check_reset_outputs("reset");
    goto(3);
    RST = 1'b0;

    // Fetch with immediate ACCESS
    goto(5);
    c0 = cyc;
    wait_cycles = 0;
    bus.iREN  = 1'b1;
    bus.iaddr = 32'h40;
    expect_hit(1'b0, 32'h8C010004, c0 + 2, "fetch");
    goto(c0 + 1);
    @(negedge CLK);
    check("fetch_ramREN",  {31'b0, bus.ramREN}, 32'h1);
    check("fetch_ramWEN",  {31'b0, bus.ramWEN}, 32'h0);
    check("fetch_ramaddr", bus.ramaddr,         32'h40);
    wait_hits("fetch", 20);
    bus.iREN = 1'b0;

    // Simultaneous fetch and data read: data wins, fetch follows 3 cycles later
    goto(cyc + 1);
    c0 = cyc;
    bus.iREN  = 1'b1;
    bus.iaddr = 32'h44;
    bus.dREN  = 1'b1;
    bus.daddr = 32'h100;
    expect_hit(1'b1, 32'hDEADBEEF, c0 + 2, "prio_d");
    expect_hit(1'b0, 32'hA5A50044, c0 + 5, "prio_i");
    while (pops < pushes - 1 && cyc < c0 + 20) begin
      @(posedge CLK);
      #1;
    end
    bus.dREN = 1'b0;
    wait_hits("prio", 20);
    bus.iREN = 1'b0;

    // Write with 3 BUSY cycles; request inputs change mid-access
    goto(cyc + 1);
    c0 = cyc;
    stall_state = BUSY;
    wait_cycles = 3;
    saw_ren     = 1'b0;
    bus.dWEN    = 1'b1;
    bus.daddr   = 32'h200;
    bus.dstore  = 32'h12345678;
    expect_hit(1'b1, 32'hDEADBEEF, c0 + 5, "write");
    for (int k = 1; k <= 4; k++) begin
      goto(c0 + k);
      if (k == 2) begin
        bus.daddr  = 32'h300;
        bus.dstore = 32'hFFFFFFFF;
      end
      @(negedge CLK);
      check($sformatf("write_ramWEN_c%0d", k),   {31'b0, bus.ramWEN}, 32'h1);
      check($sformatf("write_ramstore_c%0d", k), bus.ramstore,        32'h12345678);
      check($sformatf("write_ramaddr_c%0d", k),  bus.ramaddr,         32'h200);
    end
    wait_hits("write", 20);
    bus.dWEN = 1'b0;
    check("write_no_ramREN", {31'b0, saw_ren}, 32'h0);
    check("write_ram_addr",  wr_addr,          32'h200);
    check("write_ram_data",  wr_data,          32'h12345678);

    // ERROR twice then ACCESS: implicit retry, no error flag
    goto(cyc + 1);
    c0 = cyc;
    stall_state = ERROR;
    wait_cycles = 2;
    bus.dREN    = 1'b1;
    bus.daddr   = 32'h300;
    expect_hit(1'b1, 32'hA5A50300, c0 + 4, "err_retry");
    for (int k = 1; k <= 3; k++) begin
      goto(c0 + k);
      @(negedge CLK);
      check($sformatf("err_retry_ramREN_c%0d", k), {31'b0, bus.ramREN}, 32'h1);
    end
    wait_hits("err_retry", 20);
    bus.dREN = 1'b0;
    check("err_retry_mem_err", {31'b0, bus.mem_err}, 32'h0);

    // Timeout on a fetch with RAM stuck BUSY
    goto(cyc + 1);
    c0 = cyc;
    stall_state = BUSY;
    wait_cycles = 1000;
    bus.iREN    = 1'b1;
    bus.iaddr   = 32'h80;
    expect_hit(1'b0, 32'hBAD1BAD1, c0 + 6, "timeout");
    goto(c0 + 1);
    @(negedge CLK);
    check("timeout_strobe_rise", {31'b0, bus.ramREN}, 32'h1);
    goto(c0 + 5);
    @(negedge CLK);
    check("timeout_strobe_last", {31'b0, bus.ramREN},  32'h1);
    check("timeout_err_before",  {31'b0, bus.mem_err}, 32'h0);
    wait_hits("timeout", 20);
    bus.iREN = 1'b0;
    check("timeout_mem_err", {31'b0, bus.mem_err}, 32'h1);

    // Good access afterwards: flag stays sticky
    goto(cyc + 1);
    c0 = cyc;
    wait_cycles = 0;
    bus.iREN    = 1'b1;
    bus.iaddr   = 32'h48;
    expect_hit(1'b0, 32'hA5A50048, c0 + 2, "after_timeout");
    wait_hits("after_timeout", 20);
    bus.iREN = 1'b0;
    check("sticky_mem_err", {31'b0, bus.mem_err}, 32'h1);

    // Reset in the middle of a fetch, then restart with iREN still held
    goto(cyc + 1);
    c0 = cyc;
    wait_cycles = 1000;
    bus.iREN    = 1'b1;
    bus.iaddr   = 32'h4C;
    goto(c0 + 2);
    RST = 1'b1;
    goto(c0 + 3);
    RST = 1'b0;
    wait_cycles = 0;
    expect_hit(1'b0, 32'hA5A5004C, c0 + 5, "rst_restart");
    @(negedge CLK);
    check_reset_outputs("mid_reset");
    wait_hits("rst_restart", 20);
    bus.iREN = 1'b0;

    goto(cyc + 3);
    check("scoreboard_empty", 32'(sb.size()), 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/memory_arbiter.md
# memory_arbiter

Sequential responder on the far side of the datapath's memory request strobes (`iREN`, `dREN`, `dWEN`). It accepts at most one outstanding request, serialises instruction and data traffic onto a single-ported RAM, waits out variable RAM latency via `ramstate`, and returns a one-cycle `ihit`/`dhit` pulse with registered load data. It sits between the datapath/control unit and the RAM model, and replaces a purely combinational memory hookup.

## Interface
Parameters:
- `TIMEOUT_CYCLES`, default 255: max cycles a single RAM access may wait before being force-completed with an error; 8-bit counter range, legal values 1–255.
- `ERR_WORD`, default 32'hBAD1BAD1: load value returned on a timed-out read.

Ports (name, direction, width, meaning):
- `CLK` in 1: single clock; all state updates on the rising edge.
- `RST` in 1: synchronous, active-high reset.
- `iREN` in 1: instruction fetch request; level, held by the requester until `ihit`.
- `iaddr` in 32: fetch address.
- `dREN` in 1: data read request; level, held until `dhit`.
- `dWEN` in 1: data write request; level, held until `dhit`.
- `daddr` in 32: data address.
- `dstore` in 32: write data.
- `ihit` out 1: one-cycle pulse; `iload` is valid in the same cycle.
- `iload` out 32: registered fetch data.
- `dhit` out 1: one-cycle pulse; `dload` is valid in the same cycle for reads.
- `dload` out 32: registered read data.
- `ramREN` out 1: RAM read strobe.
- `ramWEN` out 1: RAM write strobe.
- `ramaddr` out 32: RAM address.
- `ramstore` out 32: RAM write data.
- `ramload` in 32: RAM read data.
- `ramstate` in 2: RAM status, ramstate_t (FREE, BUSY, ACCESS, ERROR).
- `mem_err` out 1: sticky flag; set on any timeout, cleared only by `RST`.

## Operation
- States: IDLE, DACC, IACC, RESP.
- IDLE:
  - If `dREN|dWEN`, latch `daddr`/`dstore`/op and go to DACC. Data requests take strict priority over fetch.
  - Otherwise, if `iREN`, latch `iaddr` and go to IACC.
  - Otherwise, stay in IDLE.
- If `dREN` and `dWEN` are both asserted, the access is a write.
- DACC/IACC:
  - Drive `ramaddr` and `ramstore` from the latched registers.
  - Drive `ramWEN` (latched write) or `ramREN` (latched read or fetch).
  - Strobes come from registers, never combinationally from the request inputs.
  - Timeout counter clears on entry and increments each cycle in the state.
- Exit from DACC/IACC:
  - `ramstate == ACCESS`: capture `ramload` into `dload` or `iload` (writes leave `dload` unchanged), then go to RESP.
  - BUSY, FREE or ERROR: hold the state and keep strobes asserted. ERROR is an implicit retry.
  - Counter reaches `TIMEOUT_CYCLES` without ACCESS: load `ERR_WORD` (reads and fetches only), set `mem_err`, go to RESP.
- RESP:
  - Strobes deasserted.
  - Pulse `dhit` or `ihit` for exactly one cycle, matching the completed access.
  - Always return to IDLE.
- Changes to request inputs or addresses while in DACC/IACC do not affect the in-flight access.
- Reset values: state IDLE, `ihit`=`dhit`=0, `iload`=`dload`=0, `ramREN`=`ramWEN`=0, `ramaddr`=`ramstore`=0, counter 0, `mem_err`=0.

## Timing
- Request sampled in IDLE at edge n. Strobes are high in cycle n+1.
- ACCESS first seen in cycle n+k (k≥1) gives the hit pulse in cycle n+k+1. Minimum request-to-hit latency is 2 cycles.
- After RESP, IDLE re-samples the requests. Back-to-back accesses therefore occur every 3 cycles at minimum.
- A requester that holds `iREN` continuously gets a new fetch each round trip.
- Each hit pulse is followed by one IDLE cycle with no hit. A requester that keeps its level high does not get a double hit.
- Fetch starvation is bounded because the datapath drops `dREN`/`dWEN` after `dhit` and only re-raises them for the next instruction.
- Timeout: with ACCESS never seen, the hit is asserted `TIMEOUT_CYCLES`+1 cycles after strobes first rise.
- `RST` mid-access: at the next edge all outputs return to reset values and the strobes drop. The interrupted access is dropped with no hit.

## Test plan
- Fetch only, RAM returns ACCESS immediately: `iREN`=1, `iaddr`=0x40, `ramload`=0x8C010004 → `ramREN`=1/`ramaddr`=0x40 in cycle 1, `ihit`=1 with `iload`=0x8C010004 in cycle 2, no `dhit`.
- Simultaneous `iREN` and `dREN` (`daddr`=0x100, RAM data 0xDEADBEEF): `dhit` first with `dload`=0xDEADBEEF; the fetch is issued starting at the next IDLE, and `ihit` follows 3 cycles after `dhit`.
- Write with 3 BUSY cycles then ACCESS: `dWEN`, `daddr`=0x200, `dstore`=0x12345678 → `ramWEN`/`ramstore` held 4 cycles, `dhit` on cycle 5, `dload` unchanged, `ramREN` never asserted.
- ERROR then ACCESS: RAM reports ERROR twice, then ACCESS → strobes remain asserted throughout, single `dhit`, `mem_err`=0.
- Timeout with `TIMEOUT_CYCLES`=4 and RAM stuck BUSY on a fetch → `ihit` 5 cycles after strobe rise, `iload`=0xBAD1BAD1, `mem_err`=1 and still 1 after subsequent good accesses until `RST`.
- `RST` asserted in IACC mid-access → next cycle all outputs 0, state IDLE, no `ihit`; after release, held `iREN` restarts the fetch with 2-cycle latency.
